// File: rtl/solver_feeder_pkg.sv
// Shared types and header field layout for the solver feeder.
// Optional SOLVER_FEEDER_TAG_EN adds a job tag to the result port.
package solver_feeder_pkg;

  localparam int ITER_W      = 16;
  localparam int TAG_W       = 8;
  localparam int HDR_TAG_LSB = 8;
  localparam int HDR_LIM_LSB = 16;

  localparam logic [ITER_W-1:0] ITER_LIMIT_HIT = 16'hFFFF;

  typedef enum logic [2:0] {
    HDR,
    LOAD_RE,
    LOAD_IM,
    START,
    WAIT_CLR,
    WAIT_DONE
  } state_t;

endpackage

// File: rtl/solver_result_buf.sv
// One-entry valid/ready result register with capture and pop.
// Carries a job tag when SOLVER_FEEDER_TAG_EN is defined.
import solver_feeder_pkg::*;

module solver_result_buf (
  input  logic              clock,
  input  logic              reset,
  input  logic              cap,
  input  logic [ITER_W-1:0] cap_count,
  input  logic              cap_err,
`ifdef SOLVER_FEEDER_TAG_EN
  input  logic [TAG_W-1:0]  cap_tag,
  output logic [TAG_W-1:0]  res_tag,
`endif
  input  logic              res_ready,
  output logic              res_valid,
  output logic [ITER_W-1:0] res_count,
  output logic              res_err,
  output logic              full
);

  assign full = res_valid;

  // A capture in the same cycle as a pop replaces the entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      res_valid <= 1'b0;
      res_count <= '0;
      res_err   <= 1'b0;
`ifdef SOLVER_FEEDER_TAG_EN
      res_tag   <= '0;
`endif
    end else if (cap) begin
      res_valid <= 1'b1;
      res_count <= cap_count;
      res_err   <= cap_err;
`ifdef SOLVER_FEEDER_TAG_EN
      res_tag   <= cap_tag;
`endif
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/solver_feeder.sv
// Job-stream front end for solver_control: loads c, starts, returns count.
// Optional SOLVER_FEEDER_TAG_EN adds res_tag from header bits [15:8].
import solver_feeder_pkg::*;

module solver_feeder #(
  parameter int LIMB_INDEX_BITS = 6,
  parameter int LIMB_BITS       = 32
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [LIMB_BITS-1:0]       in_data,
  output logic                       wr_real_en,
  output logic                       wr_imag_en,
  output logic [LIMB_INDEX_BITS-1:0] wr_ind,
  output logic [LIMB_BITS-1:0]       wr_data,
  output logic                       wr_num_limbs_en,
  output logic [LIMB_INDEX_BITS-1:0] num_limbs_data,
  output logic                       wr_iter_lim_en,
  output logic [ITER_W-1:0]          iter_lim_data,
  output logic                       start,
  input  logic                       out_ready,
  input  logic [ITER_W-1:0]          iteration_count,
  output logic                       res_valid,
  input  logic                       res_ready,
  output logic [ITER_W-1:0]          res_count,
`ifdef SOLVER_FEEDER_TAG_EN
  output logic [TAG_W-1:0]           res_tag,
`endif
  output logic                       res_err
);

  state_t                     state;
  logic [LIMB_INDEX_BITS-1:0] cnt;
  logic [LIMB_INDEX_BITS-1:0] hdr_n;
  logic [LIMB_INDEX_BITS-1:0] last;
  logic                       accept;
  logic                       res_full;
  logic                       can_cap;
  logic                       cap;
  logic                       cap_err;
  logic [ITER_W-1:0]          cap_count;

  assign hdr_n   = in_data[LIMB_INDEX_BITS-1:0];
  assign last    = num_limbs_data - LIMB_INDEX_BITS'(1);
  assign accept  = in_valid && in_ready;
  assign can_cap = !res_full || res_ready;

`ifdef SOLVER_FEEDER_TAG_EN
  logic [TAG_W-1:0] job_tag;
  logic [TAG_W-1:0] cap_tag;
  logic             unused_hdr;
  assign cap_tag    = (state == HDR) ?
                      in_data[HDR_TAG_LSB +: TAG_W] : job_tag;
  assign unused_hdr = ^in_data[HDR_TAG_LSB-1:LIMB_INDEX_BITS];
`else
  logic unused_hdr;
  assign unused_hdr = ^in_data[HDR_LIM_LSB-1:LIMB_INDEX_BITS];
`endif

  // An empty job can only be taken when its error result has room.
  always_comb begin
    in_ready = 1'b0;
    if (reset) begin
      unique case (state)
        HDR:              in_ready = !(res_full && hdr_n == '0);
        LOAD_RE, LOAD_IM: in_ready = 1'b1;
        default:          in_ready = 1'b0;
      endcase
    end
  end

  always_comb begin
    cap       = 1'b0;
    cap_err   = 1'b0;
    cap_count = iteration_count;
    if (state == HDR && accept && hdr_n == '0) begin
      cap       = 1'b1;
      cap_err   = 1'b1;
      cap_count = '0;
    end else if (state == WAIT_DONE && out_ready && can_cap) begin
      cap = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state           <= HDR;
      cnt             <= '0;
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_ind          <= '0;
      wr_data         <= '0;
      wr_num_limbs_en <= 1'b0;
      num_limbs_data  <= '0;
      wr_iter_lim_en  <= 1'b0;
      iter_lim_data   <= '0;
      start           <= 1'b0;
`ifdef SOLVER_FEEDER_TAG_EN
      job_tag         <= '0;
`endif
    end else begin
      wr_real_en      <= 1'b0;
      wr_imag_en      <= 1'b0;
      wr_num_limbs_en <= 1'b0;
      wr_iter_lim_en  <= 1'b0;
      start           <= 1'b0;
      unique case (state)
        HDR: begin
          if (accept && hdr_n != '0) begin
            num_limbs_data  <= hdr_n;
            iter_lim_data   <= in_data[HDR_LIM_LSB +: ITER_W];
            wr_num_limbs_en <= 1'b1;
            wr_iter_lim_en  <= 1'b1;
            cnt             <= '0;
            state           <= LOAD_RE;
`ifdef SOLVER_FEEDER_TAG_EN
            job_tag         <= in_data[HDR_TAG_LSB +: TAG_W];
`endif
          end
        end
        LOAD_RE, LOAD_IM: begin
          if (accept) begin
            wr_real_en <= (state == LOAD_RE);
            wr_imag_en <= (state == LOAD_IM);
            wr_ind     <= cnt;
            wr_data    <= in_data;
            if (cnt == last) begin
              cnt   <= '0;
              state <= (state == LOAD_RE) ? LOAD_IM : START;
            end else begin
              cnt <= cnt + LIMB_INDEX_BITS'(1);
            end
          end
        end
        START: begin
          start <= 1'b1;
          state <= WAIT_CLR;
        end
        // out_ready may still be high from the previous solve.
        WAIT_CLR: begin
          if (!out_ready) state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (out_ready && can_cap) state <= HDR;
        end
        default: state <= HDR;
      endcase
    end
  end

  solver_result_buf u_buf (
    .clock     (clock),
    .reset     (reset),
    .cap       (cap),
    .cap_count (cap_count),
    .cap_err   (cap_err),
`ifdef SOLVER_FEEDER_TAG_EN
    .cap_tag   (cap_tag),
    .res_tag   (res_tag),
`endif
    .res_ready (res_ready),
    .res_valid (res_valid),
    .res_count (res_count),
    .res_err   (res_err),
    .full      (res_full)
  );

endmodule

// File: tb/tb_solver_feeder.sv
// Scoreboard bench for solver_feeder with a behavioural solver model.
// Define SOLVER_FEEDER_TAG_EN to also check res_tag.
module tb_solver_feeder;

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        wr_real_en;
  logic        wr_imag_en;
  logic [5:0]  wr_ind;
  logic [31:0] wr_data;
  logic        wr_num_limbs_en;
  logic [5:0]  num_limbs_data;
  logic        wr_iter_lim_en;
  logic [15:0] iter_lim_data;
  logic        start;
  logic        out_ready;
  logic [15:0] iteration_count;
  logic        res_valid;
  logic        res_ready;
  logic [15:0] res_count;
  logic        res_err;
`ifdef SOLVER_FEEDER_TAG_EN
  logic [7:0]  res_tag;
`endif

  always #5 clock = ~clock;

  solver_feeder dut (
    .clock           (clock),
    .reset           (reset),
    .in_valid        (in_valid),
    .in_ready        (in_ready),
    .in_data         (in_data),
    .wr_real_en      (wr_real_en),
    .wr_imag_en      (wr_imag_en),
    .wr_ind          (wr_ind),
    .wr_data         (wr_data),
    .wr_num_limbs_en (wr_num_limbs_en),
    .num_limbs_data  (num_limbs_data),
    .wr_iter_lim_en  (wr_iter_lim_en),
    .iter_lim_data   (iter_lim_data),
    .start           (start),
    .out_ready       (out_ready),
    .iteration_count (iteration_count),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_count       (res_count),
`ifdef SOLVER_FEEDER_TAG_EN
    .res_tag         (res_tag),
`endif
    .res_err         (res_err)
  );

  typedef struct {
    int          kind;
    logic [5:0]  ind;
    logic [31:0] data;
    logic [15:0] lim;
  } wr_exp_t;

  typedef struct {
    logic        err;
    logic [15:0] count;
    logic [7:0]  tag;
  } res_exp_t;

  typedef struct {
    logic [15:0] count;
    int          delay;
    int          drop;
  } sol_t;

  wr_exp_t  wr_q[$];
  res_exp_t res_q[$];
  sol_t     sol_q[$];

  int checks = 0;
  int errors = 0;
  int n_starts = 0;
  int exp_starts = 0;

  wr_exp_t     mon_w;
  res_exp_t    mon_r;
  sol_t        mon_s;
  logic [63:0] got_w;
  logic [63:0] exp_w;

  // Write-bus monitor
  always @(negedge clock) begin
    if (reset && (wr_num_limbs_en || wr_iter_lim_en ||
                  wr_real_en || wr_imag_en)) begin
      checks++;
      if (wr_q.size() == 0) begin
        errors++;
        $display("FAIL wr_unexpected got en=%b%b%b%b ind=%0d",
                 wr_num_limbs_en, wr_iter_lim_en,
                 wr_real_en, wr_imag_en, wr_ind);
      end else begin
        mon_w = wr_q.pop_front();
        if (mon_w.kind == 0) begin
          got_w = {38'd0, wr_num_limbs_en, wr_iter_lim_en,
                   wr_real_en, wr_imag_en, num_limbs_data,
                   iter_lim_data};
          exp_w = {38'd0, 4'b1100, mon_w.ind, mon_w.lim};
        end else begin
          got_w = {22'd0, wr_num_limbs_en, wr_iter_lim_en,
                   wr_real_en, wr_imag_en, wr_ind, wr_data};
          exp_w = {22'd0, 2'b00, mon_w.kind == 1,
                   mon_w.kind == 2, mon_w.ind, mon_w.data};
        end
        if (got_w !== exp_w) begin
          errors++;
          $display("FAIL wr_kind%0d got %h required %h",
                   mon_w.kind, got_w, exp_w);
        end
      end
    end
  end

  // Result port monitor
  always @(negedge clock) begin
    if (reset && res_valid && res_ready) begin
      checks++;
      if (res_q.size() == 0) begin
        errors++;
        $display("FAIL res_unexpected got err=%b count=%h",
                 res_err, res_count);
      end else begin
        mon_r = res_q.pop_front();
        if ({res_err, res_count} !== {mon_r.err, mon_r.count}) begin
          errors++;
          $display("FAIL res got err=%b count=%h required err=%b count=%h",
                   res_err, res_count, mon_r.err, mon_r.count);
        end
`ifdef SOLVER_FEEDER_TAG_EN
        if (res_tag !== mon_r.tag) begin
          errors++;
          $display("FAIL res_tag got %h required %h",
                   res_tag, mon_r.tag);
        end
`endif
      end
    end
  end

  always @(negedge clock) begin
    if (reset && start) n_starts++;
  end

  // Solver model: out_ready drops after start, rises when done
  always begin
    @(negedge clock);
    if (reset && start && sol_q.size() != 0) begin
      mon_s = sol_q.pop_front();
      repeat (mon_s.drop) @(posedge clock);
      #1 out_ready = 1'b0;
      repeat (mon_s.delay) @(posedge clock);
      #1;
      iteration_count = mon_s.count;
      out_ready       = 1'b1;
    end
  end

  task automatic send_word(input logic [31:0] d, input int gap);
    bit done;
    done     = 1'b0;
    in_data  = d;
    in_valid = 1'b1;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clock);
      done = in_ready;
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL in_handshake got timeout required accept");
    end
    for (int k = 0; k < gap; k++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_job(input int n, input int lim, input int tag,
                          input int div, input int drop, input int gap,
                          input int abort_after);
    logic [31:0] re[$];
    logic [31:0] im[$];
    logic [31:0] hdr;
    wr_exp_t     w;
    res_exp_t    r;
    sol_t        s;
    int          words;
    hdr   = {lim[15:0], tag[7:0], 2'b00, n[5:0]};
    r.tag = tag[7:0];
    s.count = '0;
    s.delay = 0;
    s.drop  = drop;
    if (n == 0) begin
      r.err   = 1'b1;
      r.count = 16'h0000;
    end else begin
      if (div == 0 || div > lim) begin
        s.count = 16'hFFFF;
        s.delay = lim;
      end else begin
        s.count = div[15:0];
        s.delay = div;
      end
      r.err   = 1'b0;
      r.count = s.count;
      w.kind = 0;
      w.ind  = n[5:0];
      w.data = '0;
      w.lim  = lim[15:0];
      wr_q.push_back(w);
      for (int i = 0; i < n; i++) begin
        re.push_back($urandom);
        w.kind = 1;
        w.ind  = i[5:0];
        w.data = re[i];
        wr_q.push_back(w);
      end
      for (int i = 0; i < n; i++) begin
        im.push_back($urandom);
        w.kind = 2;
        w.ind  = i[5:0];
        w.data = im[i];
        wr_q.push_back(w);
      end
    end
    if (abort_after < 0) begin
      res_q.push_back(r);
      if (n > 0) begin
        sol_q.push_back(s);
        exp_starts++;
      end
    end
    send_word(hdr, gap);
    words = 1;
    for (int i = 0; i < n; i++) begin
      if (abort_after >= 0 && words >= abort_after) return;
      send_word(re[i], gap);
      words++;
    end
    for (int i = 0; i < n; i++) begin
      if (abort_after >= 0 && words >= abort_after) return;
      send_word(im[i], gap);
      words++;
    end
  endtask

  task automatic wait_drain(input string name);
    for (int k = 0; k < 3000 &&
         (res_q.size() != 0 || wr_q.size() != 0); k++)
      @(posedge clock);
    #1;
    checks++;
    if (res_q.size() != 0 || wr_q.size() != 0 || sol_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got res=%0d wr=%0d sol=%0d required 0",
               name, res_q.size(), wr_q.size(), sol_q.size());
    end
    in_data = 32'h1;
    #1;
    checks++;
    if ({in_ready, res_valid} !== 2'b10) begin
      errors++;
      $display("FAIL %s_idle got ready=%b valid=%b required 1 0",
               name, in_ready, res_valid);
    end
  endtask

  task automatic check_all_zero(input string name);
    checks++;
    if ({in_ready, wr_real_en, wr_imag_en, wr_num_limbs_en,
         wr_iter_lim_en, start, res_valid, res_err, wr_ind, wr_data,
         num_limbs_data, iter_lim_data, res_count} !== '0) begin
      errors++;
      $display("FAIL %s got rdy=%b en=%b%b%b%b st=%b rv=%b re=%b ind=%h d=%h n=%h l=%h c=%h required 0",
               name, in_ready, wr_real_en, wr_imag_en,
               wr_num_limbs_en, wr_iter_lim_en, start, res_valid,
               res_err, wr_ind, wr_data, num_limbs_data,
               iter_lim_data, res_count);
    end
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check_all_zero("reset_outputs");
    reset = 1'b1;
    @(posedge clock);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready got %b required 1", in_ready);
    end
  endtask

  task automatic test_basic;
    send_job(2, 100, 8'h11, 37, 1, 0, -1);
    wait_drain("basic");
  endtask

  task automatic test_limit;
    send_job(3, 5, 8'h22, 0, 1, 0, -1);
    wait_drain("limit");
  endtask

  task automatic test_zero_limbs;
    send_job(0, 77, 8'h33, 0, 1, 0, -1);
    wait_drain("zero_limbs");
  endtask

  task automatic test_stale_ready;
    send_job(1, 30, 8'h44, 9, 4, 0, -1);
    wait_drain("stale_ready");
  endtask

  task automatic test_back_to_back;
    res_ready = 1'b0;
    send_job(1, 50, 8'h55, 11, 1, 0, -1);
    send_job(2, 50, 8'h66, 22, 1, 0, -1);
    repeat (60) @(posedge clock);
    #1;
    in_data = 32'h1;
    #1;
    checks++;
    if ({res_valid, res_count} !== {1'b1, 16'd11}) begin
      errors++;
      $display("FAIL b2b_hold got valid=%b count=%h required 1 000b",
               res_valid, res_count);
    end
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL b2b_wait_done got in_ready=%b required 0", in_ready);
    end
    checks++;
    if (n_starts !== exp_starts) begin
      errors++;
      $display("FAIL b2b_starts got %0d required %0d",
               n_starts, exp_starts);
    end
    res_ready = 1'b1;
    wait_drain("back_to_back");
  endtask

  task automatic test_gaps;
    send_job(4, 200, 8'h5A, 60, 1, 2, -1);
    wait_drain("gaps");
  endtask

  task automatic test_reset_mid;
    send_job(3, 50, 8'h77, 7, 1, 0, 5);
    reset = 1'b0;
    @(posedge clock);
    #1;
    check_all_zero("reset_mid_outputs");
    wr_q.delete();
    res_q.delete();
    sol_q.delete();
    out_ready = 1'b1;
    reset     = 1'b1;
    @(posedge clock);
    #1;
    send_job(2, 40, 8'h88, 13, 1, 0, -1);
    wait_drain("reset_mid");
  endtask

  initial begin
    reset           = 1'b0;
    in_valid        = 1'b0;
    in_data         = '0;
    res_ready       = 1'b1;
    out_ready       = 1'b1;
    iteration_count = '0;
    test_reset;
    test_basic;
    test_limit;
    test_zero_limbs;
    test_stale_ready;
    test_back_to_back;
    test_gaps;
    test_reset_mid;
    checks++;
    if (n_starts !== exp_starts) begin
      errors++;
      $display("FAIL start_count got %0d required %0d",
               n_starts, exp_starts);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
